// File: rtl/game_link_ctl.sv
// rtl/game_link_ctl.sv - link-layer controller between game logic and UART core
// Sends local status on change/keepalive; publishes enemy status after repeated identical bytes.
module game_link_ctl #(
   parameter int KEEPALIVE_CYCLES = 650_000,
   parameter int TIMEOUT_CYCLES   = 6_500_000,
   parameter int CONFIRM_COUNT    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] game_status,
   output logic [7:0] enemy_status,
   output logic       link_up,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       tx_full,
   output logic [7:0] tx_data,
   output logic       wr_uart
);

   localparam int KW = $clog2(KEEPALIVE_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [KW-1:0] KA_MAX = KW'(KEEPALIVE_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_PRE = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [2:0]    CC     = 3'(CONFIRM_COUNT);

   typedef enum logic {IDLE, ISSUE} tx_state_t;

   tx_state_t     state;
   logic [7:0]    last_sent;
   logic          pending;
   logic [KW-1:0] ka_cnt;

   logic [7:0]    cand;
   logic [2:0]    match_cnt;
   logic [2:0]    match_next;
   logic [TW-1:0] to_cnt;

   // TX: the byte is captured on the IDLE->ISSUE edge, so the newest status always wins
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx_data   <= 8'h00;
         wr_uart   <= 1'b0;
         last_sent <= 8'h00;
         pending   <= 1'b1;
         ka_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pending && !tx_full) begin
                  state     <= ISSUE;
                  tx_data   <= game_status;
                  wr_uart   <= 1'b1;
                  last_sent <= game_status;
                  pending   <= 1'b0;
                  ka_cnt    <= '0;
               end else begin
                  wr_uart <= 1'b0;
                  if (ka_cnt != KA_MAX) ka_cnt <= ka_cnt + 1'b1;
                  if (game_status != last_sent || ka_cnt == KA_MAX) pending <= 1'b1;
               end
            end
            ISSUE: begin
               state   <= IDLE;
               wr_uart <= 1'b0;
               if (ka_cnt != KA_MAX) ka_cnt <= ka_cnt + 1'b1;
               if (game_status != last_sent) pending <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               wr_uart <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      match_next = 3'd1;
      if (rx_data == cand && match_cnt != 3'd0)
         match_next = (match_cnt >= CC) ? CC : match_cnt + 3'd1;
   end

   // RX: a received byte always beats a timeout landing in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         enemy_status <= 8'h00;
         link_up      <= 1'b0;
         cand         <= 8'h00;
         match_cnt    <= 3'd0;
         to_cnt       <= '0;
      end else if (rx_done) begin
         to_cnt    <= '0;
         cand      <= rx_data;
         match_cnt <= match_next;
         if (match_next == CC) begin
            enemy_status <= rx_data;
            link_up      <= 1'b1;
         end
      end else begin
         if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
         if (to_cnt >= TO_PRE) begin
            enemy_status <= 8'h00;
            link_up      <= 1'b0;
            cand         <= 8'h00;
            match_cnt    <= 3'd0;
         end
      end
   end

endmodule
